hdr_cmd_sequencer: RTL and testbench
====================================

HDR_CMD_SEQUENCER -- requirements
Module: hdr_cmd_sequencer

Interface
REQ-001 Parameter CFG_BASE, default 12'd1000: register-file address of descriptor byte 0.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd4095: maximum wait for any engine done.
REQ-003 One clock; reset is asynchronous and active-low; ports i_sdr_clk and i_sdr_rst_n.
REQ-004 i_sdr_clk  in  1  system clock; all logic on rising edge.
REQ-005 i_sdr_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_controller_en  in  1  level enable; low aborts any operation.
REQ-007 i_start  in  1  single-cycle request to execute the descriptor at CFG_BASE.
REQ-008 o_regf_rd_en  out  1  register-file read strobe.
REQ-009 o_regf_addr  out  12  register-file read address.
REQ-010 i_regf_rd_data  in  8  read data, valid 1 cycle after o_regf_rd_en.
REQ-011 o_enthdr_en / i_enthdr_done  out/in  1/1  SDR engine: broadcast 7E+W, then ENTHDR0.
REQ-012 o_sdr_en / i_sdr_done  out/in  1/1  plain SDR transfer engine.
REQ-013 o_ddr_en / i_ddr_done  out/in  1/1  HDR-DDR engine.
REQ-014 o_ccc_en / i_ccc_done  out/in  1/1  CCC engine.
REQ-015 o_cmd 8, o_dev_index 5, o_rnw 1, o_toc 1, o_wroc 1, o_dtt 3, o_def_byte 8, o_data 24  out  decoded descriptor, held from DECODE until the next start.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_done, o_error  out  1/1  single-cycle completion/failure pulses.
REQ-018 o_err_code  out  2  01 bad MODE, 10 bad CMD_ATTR, 11 timeout; held until next accepted start.

Function
REQ-019 States: IDLE, FETCH, DECODE, ENTHDR, DDR_RUN, CCC_RUN, SDR_RUN, DONE, ERR.
REQ-020 IDLE->FETCH when i_start=1 and i_controller_en=1; i_start outside IDLE is ignored.
REQ-021 FETCH: 8 cycles of o_regf_rd_en=1, o_regf_addr=CFG_BASE+k (k=0..7); byte k is captured the cycle after issue; FETCH lasts 9 cycles.
REQ-022 Byte map: b0={CMD[0],TID[3:0],CMD_ATTR[2:0]}, b1={CP,CMD[7:1]}, b2={DTT[0],RSV[1:0],DEV_INDEX}, b3={TOC,WROC,RnW,MODE[2:0],DTT[2:1]}, b4=DEF_BYTE, b5..b7=o_data[23:0] (b5 in MSBs).
REQ-023 DECODE (1 cycle): CMD_ATTR!=0 -> ERR code 10; else MODE==6 -> ENTHDR; MODE==0 -> SDR_RUN; any other MODE -> ERR code 01; attribute check has priority.
REQ-024 ENTHDR: o_enthdr_en high until i_enthdr_done; then CCC_RUN if CP=1, else DDR_RUN.
REQ-025 Each *_RUN/ENTHDR state holds exactly its own enable high; all other enables stay low; enables drop in the cycle after done is sampled.
REQ-026 DDR_RUN/CCC_RUN/SDR_RUN exit to DONE on the respective done.
REQ-027 Watchdog clears on entry to each wait state; at TIMEOUT_CYCLES cycles without done -> ERR code 11; done in the same cycle as expiry wins.
REQ-028 DONE asserts o_done for 1 cycle, ERR asserts o_error for 1 cycle; both then return to IDLE; o_done and o_error never coincide.
REQ-029 i_controller_en=0 in any non-IDLE state -> IDLE next cycle, all enables low, no o_done/o_error pulse.
REQ-030 Done inputs arriving outside the matching wait state are ignored.

Reset
REQ-031 On reset: state IDLE; all enables, o_regf_rd_en, o_busy, o_done, o_error = 0; o_regf_addr, descriptor outputs, o_err_code, watchdog = 0.
REQ-032 Reset asserted mid-operation drops all enables asynchronously; no pulse on release.

Structure
REQ-033 Shared package holds state enum, MODE encodings (SDR=0, HDR_DDR=6), error codes, descriptor byte offsets.
REQ-034 Watchdog counter is one sub-module, hdr_seq_watchdog (clear, enable, expire).

Verification
REQ-035 Descriptor MODE=6, CP=0, CMD_ATTR=0, data 8A/5A/FF -> 8 reads at 1000..1007, o_enthdr_en then o_ddr_en, o_data=24'h8A5AFF, one o_done.
REQ-036 MODE=6, CP=1 -> ENTHDR then o_ccc_en; o_ddr_en never high; one o_done.
REQ-037 MODE=3 -> no engine enable, o_error pulse, o_err_code=01; CMD_ATTR=1 with MODE=3 -> o_err_code=10.
REQ-038 MODE=0, i_sdr_done withheld, TIMEOUT_CYCLES=16 -> o_error after 16 SDR_RUN cycles, o_err_code=11; done on cycle 16 -> o_done instead.
REQ-039 i_controller_en dropped during DDR_RUN -> IDLE next cycle, o_ddr_en=0, no pulses; second i_start during FETCH ignored.

Source files
------------

// File: rtl/hdr_cmd_sequencer_pkg.sv
// hdr_cmd_sequencer_pkg
// Shared definitions for the HDR command sequencer: FSM state encoding,
// descriptor MODE encodings, error codes and descriptor byte offsets.
package hdr_cmd_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ENTHDR,
        ST_DDR_RUN,
        ST_CCC_RUN,
        ST_SDR_RUN,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Descriptor MODE field encodings that the sequencer can execute
    localparam logic [2:0] MODE_SDR     = 3'd0;
    localparam logic [2:0] MODE_HDR_DDR = 3'd6;

    // Error codes reported on o_err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_MODE = 2'b01;
    localparam logic [1:0] ERR_BAD_ATTR = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Descriptor layout in the register file, relative to CFG_BASE
    localparam int DESC_BYTES   = 8;
    localparam int OFS_CMD_LO   = 0;  // {CMD[0], TID[3:0], CMD_ATTR[2:0]}
    localparam int OFS_CMD_HI   = 1;  // {CP, CMD[7:1]}
    localparam int OFS_DEV      = 2;  // {DTT[0], RSV[1:0], DEV_INDEX[4:0]}
    localparam int OFS_MODE     = 3;  // {TOC, WROC, RnW, MODE[2:0], DTT[2:1]}
    localparam int OFS_DEF_BYTE = 4;
    localparam int OFS_DATA_HI  = 5;
    localparam int OFS_DATA_MID = 6;
    localparam int OFS_DATA_LO  = 7;

    // States in which an engine is running and the watchdog is armed
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == ST_ENTHDR) || (s == ST_DDR_RUN) ||
               (s == ST_CCC_RUN) || (s == ST_SDR_RUN);
    endfunction

endpackage

// File: rtl/hdr_cmd_sequencer_if.sv
// hdr_cmd_sequencer_if
// Bus bundle between the sequencer and its environment:
//   register-file read port : o_regf_rd_en, o_regf_addr -> ; <- i_regf_rd_data
//   engine handshakes       : o_<eng>_en -> ; <- i_<eng>_done for
//                             enthdr, sdr, ddr and ccc engines.
// The o_/i_ prefixes are relative to the sequencer (master modport).
interface hdr_cmd_sequencer_if;

    logic        o_regf_rd_en;
    logic [11:0] o_regf_addr;
    logic [7:0]  i_regf_rd_data;

    logic        o_enthdr_en;
    logic        i_enthdr_done;
    logic        o_sdr_en;
    logic        i_sdr_done;
    logic        o_ddr_en;
    logic        i_ddr_done;
    logic        o_ccc_en;
    logic        i_ccc_done;

    modport master (
        output o_regf_rd_en, o_regf_addr,
        output o_enthdr_en, o_sdr_en, o_ddr_en, o_ccc_en,
        input  i_regf_rd_data,
        input  i_enthdr_done, i_sdr_done, i_ddr_done, i_ccc_done
    );

    modport slave (
        input  o_regf_rd_en, o_regf_addr,
        input  o_enthdr_en, o_sdr_en, o_ddr_en, o_ccc_en,
        output i_regf_rd_data,
        output i_enthdr_done, i_sdr_done, i_ddr_done, i_ccc_done
    );

endinterface

// File: rtl/hdr_seq_watchdog.sv
// hdr_seq_watchdog
// Cycle counter guarding the engine wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (state entry)
//   enable     : count this cycle (a wait state is active)
//   expire     : high during the TIMEOUT_CYCLES-th enabled cycle since clear
// TIMEOUT_CYCLES must be at least 1.
module hdr_seq_watchdog #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] count_reg;

    // count_reg holds the number of enabled cycles already completed, so the
    // cycle in which it reaches TIMEOUT_CYCLES-1 is the last one allowed.
    assign expire = enable && (count_reg >= (TIMEOUT_CYCLES - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + 16'd1;
        end
    end

endmodule

// File: rtl/hdr_cmd_sequencer.sv
// hdr_cmd_sequencer
// Fetches an 8-byte command descriptor from the register file at CFG_BASE,
// decodes it and runs the matching engine sequence:
//   MODE=HDR_DDR : ENTHDR engine, then CCC (CP=1) or DDR (CP=0) engine
//   MODE=SDR     : plain SDR engine
// Ports:
//   i_sdr_clk, i_sdr_rst_n : clock, asynchronous active-low reset
//   i_controller_en        : level enable, low aborts to IDLE silently
//   i_start                : start request, honoured only in IDLE
//   bus                    : register-file read port + engine handshakes
//   o_cmd..o_data          : decoded descriptor fields
//   o_busy                 : not in IDLE
//   o_done, o_error        : one-cycle completion / failure pulses
//   o_err_code             : failure reason, kept until the next start
module hdr_cmd_sequencer
    import hdr_cmd_sequencer_pkg::*;
#(
    parameter logic [11:0] CFG_BASE       = 12'd1000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
    input  logic                 i_sdr_clk,
    input  logic                 i_sdr_rst_n,
    input  logic                 i_controller_en,
    input  logic                 i_start,
    hdr_cmd_sequencer_if.master  bus,
    output logic [7:0]           o_cmd,
    output logic [4:0]           o_dev_index,
    output logic                 o_rnw,
    output logic                 o_toc,
    output logic                 o_wroc,
    output logic [2:0]           o_dtt,
    output logic [7:0]           o_def_byte,
    output logic [23:0]          o_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [1:0]           o_err_code
);

    seq_state_t state_reg, state_next;
    logic [1:0] err_code_reg, err_code_next;
    logic [3:0] fetch_cnt_reg;
    logic       fetch_issue;
    logic       wd_clear, wd_enable, wd_expire;
    logic [2:0] cmd_attr;
    logic [2:0] mode;
    logic       cp;
    logic [DESC_BYTES-1:0][7:0] desc_bytes;

    // ------------------------------------------------------------------
    // Descriptor fetch: reads issue while fetch_cnt_reg is 0..7, and byte k
    // arrives while the counter is k+1, so FETCH spans 9 cycles.
    // ------------------------------------------------------------------
    assign fetch_issue      = (state_reg == ST_FETCH) && !fetch_cnt_reg[3];
    assign bus.o_regf_rd_en = fetch_issue;
    assign bus.o_regf_addr  = fetch_issue ? (CFG_BASE + 12'(fetch_cnt_reg)) : 12'd0;

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            fetch_cnt_reg <= '0;
        end else if (state_reg == ST_FETCH) begin
            fetch_cnt_reg <= fetch_cnt_reg + 4'd1;
        end else begin
            fetch_cnt_reg <= '0;
        end
    end

    for (genvar gi = 0; gi < DESC_BYTES; gi++) begin : g_desc
        logic [7:0] byte_reg;
        always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
            if (!i_sdr_rst_n) begin
                byte_reg <= '0;
            end else if ((state_reg == ST_FETCH) && (fetch_cnt_reg == 4'(gi + 1))) begin
                byte_reg <= bus.i_regf_rd_data;
            end
        end
        assign desc_bytes[gi] = byte_reg;
    end

    // ------------------------------------------------------------------
    // Field decode. The byte buffer is only rewritten during FETCH, so the
    // decoded outputs stay stable from DECODE until the next start.
    // ------------------------------------------------------------------
    assign cmd_attr    = desc_bytes[OFS_CMD_LO][2:0];
    assign cp          = desc_bytes[OFS_CMD_HI][7];
    assign mode        = desc_bytes[OFS_MODE][4:2];
    assign o_cmd       = {desc_bytes[OFS_CMD_HI][6:0], desc_bytes[OFS_CMD_LO][7]};
    assign o_dev_index = desc_bytes[OFS_DEV][4:0];
    assign o_dtt       = {desc_bytes[OFS_MODE][1:0], desc_bytes[OFS_DEV][7]};
    assign o_toc       = desc_bytes[OFS_MODE][7];
    assign o_wroc      = desc_bytes[OFS_MODE][6];
    assign o_rnw       = desc_bytes[OFS_MODE][5];
    assign o_def_byte  = desc_bytes[OFS_DEF_BYTE];
    assign o_data      = {desc_bytes[OFS_DATA_HI], desc_bytes[OFS_DATA_MID],
                          desc_bytes[OFS_DATA_LO]};

    // TID and the reserved bits are carried in the descriptor but not used here
    logic unused_desc_bits;
    assign unused_desc_bits = ^{desc_bytes[OFS_CMD_LO][6:3], desc_bytes[OFS_DEV][6:5]};

    // ------------------------------------------------------------------
    // Watchdog: restarted on every state change, counting in wait states.
    // ------------------------------------------------------------------
    assign wd_enable = is_wait_state(state_reg);
    assign wd_clear  = (state_next != state_reg);

    hdr_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (i_sdr_clk),
        .rst_n  (i_sdr_rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            state_reg    <= ST_IDLE;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        if ((state_reg != ST_IDLE) && !i_controller_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start && i_controller_en) begin
                        state_next    = ST_FETCH;
                        err_code_next = ERR_NONE;
                    end
                end
                ST_FETCH: begin
                    if (fetch_cnt_reg == 4'd8) begin
                        state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cmd_attr != 3'd0) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_BAD_ATTR;
                    end else if (mode == MODE_HDR_DDR) begin
                        state_next = ST_ENTHDR;
                    end else if (mode == MODE_SDR) begin
                        state_next = ST_SDR_RUN;
                    end else begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_BAD_MODE;
                    end
                end
                // In every wait state a done sampled together with expiry wins
                ST_ENTHDR: begin
                    if (bus.i_enthdr_done) begin
                        state_next = cp ? ST_CCC_RUN : ST_DDR_RUN;
                    end else if (wd_expire) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_TIMEOUT;
                    end
                end
                ST_DDR_RUN: begin
                    if (bus.i_ddr_done) begin
                        state_next = ST_DONE;
                    end else if (wd_expire) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_TIMEOUT;
                    end
                end
                ST_CCC_RUN: begin
                    if (bus.i_ccc_done) begin
                        state_next = ST_DONE;
                    end else if (wd_expire) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_TIMEOUT;
                    end
                end
                ST_SDR_RUN: begin
                    if (bus.i_sdr_done) begin
                        state_next = ST_DONE;
                    end else if (wd_expire) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_TIMEOUT;
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                ST_ERR:   state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Moore outputs; enables come straight from the state register so an
    // asynchronous reset removes them immediately.
    assign bus.o_enthdr_en = (state_reg == ST_ENTHDR);
    assign bus.o_ddr_en    = (state_reg == ST_DDR_RUN);
    assign bus.o_ccc_en    = (state_reg == ST_CCC_RUN);
    assign bus.o_sdr_en    = (state_reg == ST_SDR_RUN);
    assign o_busy          = (state_reg != ST_IDLE);
    // An abort landing on the DONE/ERR cycle suppresses the pulse
    assign o_done          = (state_reg == ST_DONE) && i_controller_en;
    assign o_error         = (state_reg == ST_ERR) && i_controller_en;
    assign o_err_code      = err_code_reg;

endmodule

// File: tb/tb_hdr_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_hdr_cmd_sequencer;

    localparam int TMO        = 16;
    localparam int BASE       = 1000;
    localparam int ENG_ENTHDR = 0;
    localparam int ENG_SDR    = 1;
    localparam int ENG_DDR    = 2;
    localparam int ENG_CCC    = 3;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ctrl_en = 1'b0;
    logic start = 1'b0;
    logic [7:0]  o_cmd;
    logic [4:0]  o_dev_index;
    logic        o_rnw, o_toc, o_wroc;
    logic [2:0]  o_dtt;
    logic [7:0]  o_def_byte;
    logic [23:0] o_data;
    logic        o_busy, o_done, o_error;
    logic [1:0]  o_err_code;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int n_reads, n_enthdr, n_ddr, n_ccc, n_sdr;

    logic [11:0] addr_q[$];
    exp_t        res_q[$];
    logic [7:0]  regmem [0:4095];

    logic [7:0]  exp_cmd, exp_def;
    logic [4:0]  exp_dev;
    logic [2:0]  exp_dtt;
    logic        exp_toc, exp_wroc, exp_rnw;
    logic [23:0] exp_data;

    hdr_cmd_sequencer_if bus();

    hdr_cmd_sequencer #(
        .CFG_BASE       (12'd1000),
        .TIMEOUT_CYCLES (16'(TMO))
    ) dut (
        .i_sdr_clk       (clk),
        .i_sdr_rst_n     (rst_n),
        .i_controller_en (ctrl_en),
        .i_start         (start),
        .bus             (bus),
        .o_cmd           (o_cmd),
        .o_dev_index     (o_dev_index),
        .o_rnw           (o_rnw),
        .o_toc           (o_toc),
        .o_wroc          (o_wroc),
        .o_dtt           (o_dtt),
        .o_def_byte      (o_def_byte),
        .o_data          (o_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_err_code      (o_err_code)
    );

    always #5 clk = ~clk;

    // Register-file model: data returned one cycle after the read strobe
    always @(posedge clk) begin
        if (!rst_n) bus.i_regf_rd_data <= 8'h00;
        else if (bus.o_regf_rd_en) bus.i_regf_rd_data <= regmem[bus.o_regf_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pops on reads and on completion pulses
    always @(negedge clk) begin
        if (bus.o_regf_rd_en) begin
            n_reads++;
            cmp_cnt++;
            assert (addr_q.size() > 0) else begin
                err_cnt++;
                $error("FAIL fetch_extra: read at %0d observed, no read expected", bus.o_regf_addr);
            end
            if (addr_q.size() > 0) check("fetch_addr", 32'(bus.o_regf_addr), 32'(addr_q.pop_front()));
        end
        if (bus.o_enthdr_en) n_enthdr++;
        if (bus.o_ddr_en)    n_ddr++;
        if (bus.o_ccc_en)    n_ccc++;
        if (bus.o_sdr_en)    n_sdr++;
        if (o_busy)
            check("enable_onehot", 32'($countones({bus.o_enthdr_en, bus.o_ddr_en,
                                                     bus.o_ccc_en, bus.o_sdr_en}) <= 1), 32'd1);
        if (o_done || o_error) begin
            cmp_cnt++;
            assert (res_q.size() > 0) else begin
                err_cnt++;
                $error("FAIL unexpected_pulse: done=%0b error=%0b observed, no pulse expected", o_done, o_error);
            end
            if (res_q.size() > 0) begin
                exp_t e;
                e = res_q.pop_front();
                check("pulse_kind", {30'd0, o_done, o_error}, e.is_err ? 32'd1 : 32'd2);
                check("pulse_err_code", 32'(o_err_code), 32'(e.code));
                $display("txn: %s err_code=%0b", o_done ? "done" : "error", o_err_code);
            end
        end
    end

    function automatic logic en_of(input int eng);
        case (eng)
            ENG_ENTHDR: return bus.o_enthdr_en;
            ENG_SDR:    return bus.o_sdr_en;
            ENG_DDR:    return bus.o_ddr_en;
            default:    return bus.o_ccc_en;
        endcase
    endfunction

    task automatic set_done(input int eng, input logic v);
        case (eng)
            ENG_ENTHDR: bus.i_enthdr_done = v;
            ENG_SDR:    bus.i_sdr_done = v;
            ENG_DDR:    bus.i_ddr_done = v;
            default:    bus.i_ccc_done = v;
        endcase
    endtask

    task automatic wait_en(input int eng, input string tag);
        int waited = 0;
        while (!en_of(eng) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(en_of(eng)), 32'd1);
    endtask

    // Wait for the engine enable, leave it running 'delay' more cycles, then pulse done
    task automatic serve(input int eng, input int delay, input string tag);
        wait_en(eng, tag);
        repeat (delay) @(negedge clk);
        set_done(eng, 1'b1);
        @(negedge clk);
        set_done(eng, 1'b0);
    endtask

    task automatic pulse_done(input int eng);
        set_done(eng, 1'b1);
        @(negedge clk);
        set_done(eng, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int waited = 0;
        @(negedge clk);
        while (o_busy && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic load_desc(input logic [7:0] cmd, input logic [2:0] attr, input logic cp,
                             input logic [2:0] mode, input logic [4:0] dev, input logic [2:0] dtt,
                             input logic toc, input logic wroc, input logic rnw,
                             input logic [7:0] def, input logic [23:0] data);
        regmem[BASE + 0] = {cmd[0], 4'hA, attr};
        regmem[BASE + 1] = {cp, cmd[7:1]};
        regmem[BASE + 2] = {dtt[0], 2'b11, dev};
        regmem[BASE + 3] = {toc, wroc, rnw, mode, dtt[2:1]};
        regmem[BASE + 4] = def;
        regmem[BASE + 5] = data[23:16];
        regmem[BASE + 6] = data[15:8];
        regmem[BASE + 7] = data[7:0];
        exp_cmd = cmd; exp_dev = dev; exp_dtt = dtt; exp_toc = toc;
        exp_wroc = wroc; exp_rnw = rnw; exp_def = def; exp_data = data;
    endtask

    task automatic launch(input bit expect_pulse, input logic is_err, input logic [1:0] code);
        exp_t e;
        n_reads = 0; n_enthdr = 0; n_ddr = 0; n_ccc = 0; n_sdr = 0;
        for (int k = 0; k < 8; k++) addr_q.push_back(12'(BASE + k));
        if (expect_pulse) begin
            e.is_err = is_err;
            e.code   = code;
            res_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_decode(input string tag);
        check({tag, "_cmd"},  32'(o_cmd), 32'(exp_cmd));
        check({tag, "_dev"},  32'(o_dev_index), 32'(exp_dev));
        check({tag, "_flags"}, {24'd0, o_toc, o_wroc, o_rnw, o_dtt, 2'b00},
                               {24'd0, exp_toc, exp_wroc, exp_rnw, exp_dtt, 2'b00});
        check({tag, "_def"},  32'(o_def_byte), 32'(exp_def));
        check({tag, "_data"}, 32'(o_data), 32'(exp_data));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        bus.i_enthdr_done = 1'b0;
        bus.i_sdr_done    = 1'b0;
        bus.i_ddr_done    = 1'b0;
        bus.i_ccc_done    = 1'b0;
        for (int a = 0; a < 4096; a++) regmem[a] = 8'h00;
        ctrl_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {24'd0, o_busy, o_done, o_error, bus.o_regf_rd_en, bus.o_enthdr_en,
                           bus.o_ddr_en, bus.o_ccc_en, bus.o_sdr_en}, 32'd0);
        check("rst_addr", 32'(bus.o_regf_addr), 32'd0);
        check("rst_err_code", 32'(o_err_code), 32'd0);
        check("rst_data", {o_data, o_cmd}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);

        // HDR-DDR, CP=0, plus a second start during FETCH that must be ignored
        load_desc(8'h3D, 3'd0, 1'b0, 3'd6, 5'h13, 3'b101, 1'b1, 1'b0, 1'b1, 8'hA5, 24'h8A5AFF);
        launch(1'b1, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve(ENG_ENTHDR, 2, "ddr_enthdr_seen");
        serve(ENG_DDR, 3, "ddr_ddr_seen");
        wait_idle("ddr_idle");
        check("ddr_reads", 32'(n_reads), 32'd8);
        check("ddr_enthdr_cycles", 32'(n_enthdr), 32'd3);
        check("ddr_ddr_cycles", 32'(n_ddr), 32'd4);
        check("ddr_other_en", 32'(n_ccc + n_sdr), 32'd0);
        check_decode("ddr");

        // HDR-DDR, CP=1 -> CCC engine; a stray ddr_done during CCC_RUN is ignored
        load_desc(8'hC2, 3'd0, 1'b1, 3'd6, 5'h05, 3'b010, 1'b0, 1'b1, 1'b0, 8'h3C, 24'h123456);
        launch(1'b1, 1'b0, 2'b00);
        serve(ENG_ENTHDR, 0, "ccc_enthdr_seen");
        pulse_done(ENG_DDR);
        serve(ENG_CCC, 4, "ccc_ccc_seen");
        wait_idle("ccc_idle");
        check("ccc_enthdr_cycles", 32'(n_enthdr), 32'd1);
        check("ccc_ccc_cycles", 32'(n_ccc), 32'd6);
        check("ccc_ddr_cycles", 32'(n_ddr), 32'd0);
        check_decode("ccc");

        // Bad MODE
        load_desc(8'h11, 3'd0, 1'b0, 3'd3, 5'h01, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000001);
        launch(1'b1, 1'b1, 2'b01);
        wait_idle("mode_idle");
        check("mode_no_engine", 32'(n_enthdr + n_ddr + n_ccc + n_sdr), 32'd0);
        check("mode_code_held", 32'(o_err_code), 32'd1);

        // Bad CMD_ATTR has priority over bad MODE, and over a valid MODE
        load_desc(8'h22, 3'd1, 1'b0, 3'd3, 5'h02, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000002);
        launch(1'b1, 1'b1, 2'b10);
        wait_idle("attr_idle");
        check("attr_code_held", 32'(o_err_code), 32'd2);
        load_desc(8'h23, 3'd4, 1'b0, 3'd0, 5'h02, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000003);
        launch(1'b1, 1'b1, 2'b10);
        wait_idle("attr_sdr_idle");
        check("attr_sdr_no_engine", 32'(n_sdr), 32'd0);

        // SDR with done withheld: timeout after exactly TMO cycles
        load_desc(8'h44, 3'd0, 1'b0, 3'd0, 5'h1F, 3'b111, 1'b1, 1'b1, 1'b1, 8'hFF, 24'hABCDEF);
        launch(1'b1, 1'b1, 2'b11);
        wait_idle("tmo_idle");
        check("tmo_sdr_cycles", 32'(n_sdr), 32'(TMO));
        check("tmo_code_held", 32'(o_err_code), 32'd3);

        // SDR with done in the expiry cycle: done wins
        launch(1'b1, 1'b0, 2'b00);
        serve(ENG_SDR, TMO - 1, "edge_sdr_seen");
        wait_idle("edge_idle");
        check("edge_sdr_cycles", 32'(n_sdr), 32'(TMO));
        check("edge_code", 32'(o_err_code), 32'd0);

        // Controller disable during DDR_RUN: silent abort
        load_desc(8'h55, 3'd0, 1'b0, 3'd6, 5'h0A, 3'b001, 1'b0, 1'b0, 1'b1, 8'h77, 24'h0F0F0F);
        launch(1'b0, 1'b0, 2'b00);
        serve(ENG_ENTHDR, 1, "abort_enthdr_seen");
        wait_en(ENG_DDR, "abort_ddr_seen");
        ctrl_en = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_ddr_en", 32'(bus.o_ddr_en), 32'd0);
        ctrl_en = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_stays_idle", 32'(o_busy), 32'd0);
        check("abort_reads", 32'(n_reads), 32'd8);

        // Asynchronous reset in the middle of SDR_RUN
        load_desc(8'h66, 3'd0, 1'b0, 3'd0, 5'h0B, 3'b011, 1'b0, 1'b1, 1'b0, 8'h12, 24'h445566);
        launch(1'b0, 1'b0, 2'b00);
        wait_en(ENG_SDR, "rst_sdr_seen");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sdr_en", 32'(bus.o_sdr_en), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_data", 32'(o_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_idle", 32'(o_busy), 32'd0);

        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("res_q_empty", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
